// File: rtl/rr_share_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters, with a bounded hold per tenure.
// Optional build macro RR_SHARE_ARBITER_LOCK_EN adds a lock input that suppresses forced release.
module rr_share_arbiter #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
`ifdef RR_SHARE_ARBITER_LOCK_EN
    input  logic             lock,
`endif
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy
);

    // Handshake: req[i] is a level held for as long as requester i wants the resource;
    // gnt[i] (registered, one-hot) is the acceptance and stays set until the tenure ends
    // by req[i] dropping, last[i] on a granted cycle, or the hold limit.

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] nxt_hold;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] nxt_owner;
    logic [N-1:0]     gnt_q;
    logic [N-1:0]     nxt_gnt;
    logic [IDX_W-1:0] pick_base;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             pick_any;
    logic             at_limit;
    logic             limit_release;
    logic             release_now;

    // A releasing owner becomes the search base, so it is the last candidate considered.
    always_comb begin : pick
        pick_base = (state == OWN) ? owner : rr_ptr;
        pick_any  = 1'b0;
        pick_idx  = '0;
        cand_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            cand_idx = IDX_W'((int'(pick_base) + k) % N);
            if (!pick_any && req[cand_idx]) begin
                pick_any = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_comb begin : release_logic
        at_limit = (hold_cnt == HOLD_LAST);
`ifdef RR_SHARE_ARBITER_LOCK_EN
        limit_release = at_limit && !lock;
`else
        limit_release = at_limit;
`endif
        release_now = !req[owner] || last[owner] || limit_release;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rr_ptr   <= IDX_W'(N - 1);
            owner    <= '0;
            gnt_q    <= '0;
        end else begin
            state    <= nxt_state;
            hold_cnt <= nxt_hold;
            rr_ptr   <= nxt_ptr;
            owner    <= nxt_owner;
            gnt_q    <= nxt_gnt;
        end
    end

    always_comb begin : next_state
        nxt_state = state;
        nxt_hold  = hold_cnt;
        nxt_ptr   = rr_ptr;
        nxt_owner = owner;
        nxt_gnt   = gnt_q;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    nxt_state          = OWN;
                    nxt_hold           = '0;
                    nxt_owner          = pick_idx;
                    nxt_gnt            = '0;
                    nxt_gnt[pick_idx]  = 1'b1;
                end
            end
            OWN: begin
                if (release_now) begin
                    nxt_ptr  = owner;
                    nxt_hold = '0;
                    nxt_gnt  = '0;
                    if (pick_any) begin
                        nxt_owner         = pick_idx;
                        nxt_gnt[pick_idx] = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else if (!at_limit) begin
                    // Saturates at the limit only while locked; otherwise the limit always releases.
                    nxt_hold = hold_cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_gnt   = '0;
            end
        endcase
    end

    always_comb begin : outputs
        gnt     = gnt_q;
        gnt_idx = owner;
        busy    = |gnt_q;
    end

endmodule

// File: tb/tb_rr_share_arbiter.sv
// Directed bench for rr_share_arbiter (N=2, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] last;
`ifdef RR_SHARE_ARBITER_LOCK_EN
    logic       lock;
`endif
    logic [1:0] gnt;
    logic [0:0] gnt_idx;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    rr_share_arbiter #(.N(2), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .last    (last),
`ifdef RR_SHARE_ARBITER_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        last  = 2'b00;
`ifdef RR_SHARE_ARBITER_LOCK_EN
        lock  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        last  = 2'b00;
`ifdef RR_SHARE_ARBITER_LOCK_EN
        lock  = 1'b0;
`endif
        #2;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_idx", 32'(gnt_idx), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        do_reset();

        // Single request: grant one cycle later, then drop returns to idle
        req = 2'b01;
        step();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_idx", 32'(gnt_idx), 32'h0);
        chk("first_busy", 32'(busy), 32'h1);
        req = 2'b00;
        step();
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_busy", 32'(busy), 32'h0);
        chk("drop_idx_hold", 32'(gnt_idx), 32'h0);

        // Both requesting: 8 cycles each, no bubble
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("alt0_c%0d", i), 32'(gnt), 32'h1);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("alt1_c%0d", i), 32'(gnt), 32'h2);
            chk($sformatf("alt1_busy%0d", i), 32'(busy), 32'h1);
        end
        step();
        chk("alt_back0", 32'(gnt), 32'h1);

        // Owner 0 marks last on its 3rd granted cycle
        step();
        step();
        chk("last_pre", 32'(gnt), 32'h1);
        last = 2'b01;
        step();
        last = 2'b00;
        chk("last_gnt", 32'(gnt), 32'h2);
        chk("last_idx", 32'(gnt_idx), 32'h1);

        // last from a non-owner and a non-owner dropping req are ignored
        last = 2'b01;
        step();
        last = 2'b00;
        chk("nonowner_last", 32'(gnt), 32'h2);
        req = 2'b10;
        step();
        chk("nonowner_drop", 32'(gnt), 32'h2);

        // Sole requester re-granted after forced release with no bubble
        do_reset();
        req = 2'b10;
        step();
        chk("sole_first", 32'(gnt), 32'h2);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("sole_c%0d", i), 32'(gnt), 32'h2);
        end
        req = 2'b00;
        step();
        chk("sole_idle_gnt", 32'(gnt), 32'h0);
        chk("sole_idle_idx", 32'(gnt_idx), 32'h1);

        // Asynchronous reset in mid-tenure clears before the next edge
        req = 2'b10;
        step();
        chk("async_pre", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        req = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 2'b11;
        step();
        chk("async_after_gnt", 32'(gnt), 32'h1);
        chk("async_after_idx", 32'(gnt_idx), 32'h0);

`ifdef RR_SHARE_ARBITER_LOCK_EN
        // Lock suppresses forced release; dropping it releases at once
        do_reset();
        lock = 1'b1;
        req  = 2'b11;
        step();
        chk("lock_first", 32'(gnt), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("lock_c%0d", i), 32'(gnt), 32'h1);
        end
        lock = 1'b0;
        step();
        chk("unlock_gnt", 32'(gnt), 32'h2);
        chk("unlock_idx", 32'(gnt_idx), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
